// File: rtl/decode_execute_reg.sv
// ----------------------------------------------------------------------------
// decode_execute_reg
//
// Decode-to-execute pipeline register. It captures the decoded instruction,
// its PC, both register operands and the immediate, and presents them to the
// execute stage. The block also:
//   - detects load-use hazards, inserts a single bubble and back-pressures
//     decode for that cycle;
//   - flushes EX to a NOP on a taken branch/jump reported by execute;
//   - keeps saturating hazard-bubble and flush counters.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   id_valid         decode presents a valid instruction
//   id_ready         decode payload is accepted (or discarded) this cycle
//   id_instruction   decoded instruction word
//   id_pc            PC of the decode instruction
//   id_rs1_data      rs1 operand
//   id_rs2_data      rs2 operand
//   id_imm           sign-extended immediate
//   flush            taken branch/jump from execute
//   ex_ready         execute can advance
//   ex_valid         EX payload valid
//   ex_instruction   EX instruction word
//   ex_pc            EX PC
//   ex_rs1_data      EX rs1 operand
//   ex_rs2_data      EX rs2 operand
//   ex_imm           EX immediate
//   load_use_stall   hazard bubble inserted this cycle (combinational)
//   bubble_cnt       saturating count of hazard bubbles
//   flush_cnt        saturating count of flush cycles
// ----------------------------------------------------------------------------
module decode_execute_reg #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [31:0]      id_instruction,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic             flush,
    input  logic             ex_ready,
    output logic             ex_valid,
    output logic [31:0]      ex_instruction,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic             load_use_stall,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [6:0]       OPC_JALR   = 7'b1100111;
    localparam logic [6:0]       OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]       OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]       OPC_STORE  = 7'b0100011;
    localparam logic [6:0]       OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0]       OPC_OP     = 7'b0110011;
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic uses_rs1(input logic [6:0] opc);
        return (opc == OPC_JALR)  || (opc == OPC_BRANCH) || (opc == OPC_LOAD) ||
               (opc == OPC_STORE) || (opc == OPC_OPIMM)  || (opc == OPC_OP);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opc);
        return (opc == OPC_BRANCH) || (opc == OPC_STORE) || (opc == OPC_OP);
    endfunction

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_ONE;
    endfunction

    logic             valid_q, valid_d;
    logic [31:0]      instr_q, instr_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  rs1_q, rs1_d;
    logic [XLEN-1:0]  rs2_q, rs2_d;
    logic [XLEN-1:0]  imm_q, imm_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic [4:0] ex_rd;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [6:0] id_opc;
    logic       hazard;

    assign ex_rd  = instr_q[11:7];
    assign id_rs1 = id_instruction[19:15];
    assign id_rs2 = id_instruction[24:20];
    assign id_opc = id_instruction[6:0];

    // A load in EX whose destination is read by the decode instruction must
    // not be bypassed; x0 destinations never create a dependency.
    assign hazard = valid_q && (instr_q[6:0] == OPC_LOAD) && (ex_rd != 5'd0) && id_valid &&
                    ((uses_rs1(id_opc) && (id_rs1 == ex_rd)) ||
                     (uses_rs2(id_opc) && (id_rs2 == ex_rd)));

    always_comb begin
        valid_d        = valid_q;
        instr_d        = instr_q;
        pc_d           = pc_q;
        rs1_d          = rs1_q;
        rs2_d          = rs2_q;
        imm_d          = imm_q;
        bubble_cnt_d   = bubble_cnt_q;
        flush_cnt_d    = flush_cnt_q;
        id_ready       = 1'b0;
        load_use_stall = 1'b0;

        if (rst) begin
            // Register reset happens in the state process; nothing is accepted.
            id_ready = 1'b0;
        end else if (flush) begin
            // Wrong-path decode payload is consumed and dropped.
            id_ready    = 1'b1;
            valid_d     = 1'b0;
            instr_d     = NOP_INSTR;
            pc_d        = '0;
            rs1_d       = '0;
            rs2_d       = '0;
            imm_d       = '0;
            flush_cnt_d = sat_inc(flush_cnt_q);
        end else if (!ex_ready) begin
            id_ready = 1'b0;
        end else if (hazard) begin
            // One bubble clears the load from EX, so the stall self-terminates.
            id_ready       = 1'b0;
            load_use_stall = 1'b1;
            valid_d        = 1'b0;
            instr_d        = NOP_INSTR;
            pc_d           = '0;
            rs1_d          = '0;
            rs2_d          = '0;
            imm_d          = '0;
            bubble_cnt_d   = sat_inc(bubble_cnt_q);
        end else begin
            id_ready = 1'b1;
            if (id_valid) begin
                valid_d = 1'b1;
                instr_d = id_instruction;
                pc_d    = id_pc;
                rs1_d   = id_rs1_data;
                rs2_d   = id_rs2_data;
                imm_d   = id_imm;
            end else begin
                valid_d = 1'b0;
                instr_d = NOP_INSTR;
                pc_d    = '0;
                rs1_d   = '0;
                rs2_d   = '0;
                imm_d   = '0;
            end
        end
    end

    // Decode -> execute boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= 1'b0;
            instr_q      <= NOP_INSTR;
            pc_q         <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            imm_q        <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            pc_q         <= pc_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            imm_q        <= imm_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign ex_valid       = valid_q;
    assign ex_instruction = instr_q;
    assign ex_pc          = pc_q;
    assign ex_rs1_data    = rs1_q;
    assign ex_rs2_data    = rs2_q;
    assign ex_imm         = imm_q;
    assign bubble_cnt     = bubble_cnt_q;
    assign flush_cnt      = flush_cnt_q;

endmodule
